// File: rtl/mem_ctrl_multi_pkg.sv
// Shared types for the multi-channel beat assembler.
// Latency: n/a (types and helpers only).
// Backpressure: n/a.
package mem_ctrl_pkg;

    // Per-channel assembly state; encodings are visible on reg_state/coverage.
    typedef enum logic [1:0] {
        ST_READY   = 2'd0,
        ST_PENDING = 2'd1,
        ST_BUSY    = 2'd2
    } ch_state_e;

    // Beat counter width, enough for BEATS up to 4.
    localparam int CNT_W = 3;

    // Width of a channel index; never narrower than one bit.
    function automatic int idx_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/mem_ctrl_multi_if.sv
// Channel-in / word-out handshake bundle for mem_ctrl_multi.
// Latency: n/a (wires only).
// Backpressure: in_ready per channel, out_ready from the sink.
// master: stimulus/sink side; slave: the controller.
interface mem_ctrl_multi_if #(
    parameter int NCH   = 3,
    parameter int BEATW = 2,
    parameter int BEATS = 2
);
    import mem_ctrl_pkg::*;

    localparam int DATAW = BEATW * BEATS;
    localparam int CHW   = idx_w(NCH);

    logic [NCH-1:0]       in_valid;
    logic [NCH*BEATW-1:0] in_data;
    logic [NCH-1:0]       in_ready;
    logic                 out_valid;
    logic                 out_ready;
    logic [DATAW-1:0]     out_data;
    logic [CHW-1:0]       out_ch;

    modport master (
        output in_valid, in_data, out_ready,
        input  in_ready, out_valid, out_data, out_ch
    );

    modport slave (
        input  in_valid, in_data, out_ready,
        output in_ready, out_valid, out_data, out_ch
    );

endinterface

// File: rtl/mem_ctrl_multi_toggle_cov.sv
// Sticky toggle detector: flags the first change of a 1-bit signal.
// Latency: toggled rises the cycle after the sampled change.
// Backpressure: none.
// Ports: clock, reset (async high), signal (observed), toggled (sticky flag).
module toggle_cov (
    input  logic clock,
    input  logic reset,
    input  logic signal,
    output logic toggled
);

    logic last;

    // last starts at 0, so a signal that idles high registers as a toggle.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            last    <= 1'b0;
            toggled <= 1'b0;
        end else begin
            last <= signal;
            if (signal != last)
                toggled <= 1'b1;
        end
    end

endmodule

// File: rtl/mem_ctrl_multi.sv
// Assembles BEATS beats per channel into one word; round-robin output arbiter.
// Latency: word presented the cycle after its last beat is accepted.
// Backpressure: a BUSY channel holds (in_ready=0) until granted with out_ready.
// Ports: clock, reset (async high), meta_reset (sync clear of state coverage),
//        bus (slave handshake), coverage (toggle bits), io_cov_sum, bug.
module mem_ctrl_multi
    import mem_ctrl_pkg::*;
#(
    parameter int NCH   = 3,
    parameter int BEATW = 2,
    parameter int BEATS = 2
) (
    input  logic                 clock,
    input  logic                 reset,
    input  logic                 meta_reset,
    mem_ctrl_multi_if.slave      bus,
    output logic [3*NCH-1:0]     coverage,
    output logic [2*NCH:0]       io_cov_sum,
    output logic                 bug
);

    localparam int DATAW = BEATW * BEATS;
    localparam int CHW   = idx_w(NCH);
    localparam int SW    = 2 * NCH;

    ch_state_e        st   [NCH];
    logic [CNT_W-1:0] cnt  [NCH];
    logic [DATAW-1:0] data [NCH];

    logic [NCH-1:0] busy;
    logic [CHW-1:0] rr_ptr;
    logic [CHW-1:0] grant;
    logic           xfer;
    logic [SW-1:0]  state_vec;
    logic [SW-1:0]  reg_state;

    logic [(1<<SW)-1:0] covmap;
    logic [SW:0]        covsum;

    always_comb begin
        busy      = '0;
        state_vec = '0;
        for (int i = 0; i < NCH; i++) begin
            busy[i]            = (st[i] == ST_BUSY);
            state_vec[2*i +: 2] = st[i];
        end
    end

    // First BUSY channel strictly after rr_ptr, wrapping.
    always_comb begin
        logic found;
        int   idx;
        grant = rr_ptr;
        found = 1'b0;
        for (int k = 1; k <= NCH; k++) begin
            idx = (int'(rr_ptr) + k) % NCH;
            if (!found && busy[idx]) begin
                grant = CHW'(idx);
                found = 1'b1;
            end
        end
    end

    assign bus.in_ready  = ~busy;
    assign bus.out_valid = |busy;
    assign bus.out_ch    = grant;
    assign bus.out_data  = bus.out_valid ? data[grant] : '0;
    assign xfer          = bus.out_valid && bus.out_ready;
    assign bug           = &busy;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < NCH; i++) begin
                st[i]   <= ST_READY;
                cnt[i]  <= '0;
                data[i] <= '0;
            end
        end else begin
            for (int i = 0; i < NCH; i++) begin
                case (st[i])
                    ST_READY: begin
                        if (bus.in_valid[i]) begin
                            data[i] <= DATAW'(bus.in_data[i*BEATW +: BEATW]);
                            cnt[i]  <= CNT_W'(1);
                            st[i]   <= (BEATS == 1) ? ST_BUSY : ST_PENDING;
                        end
                    end
                    ST_PENDING: begin
                        if (bus.in_valid[i]) begin
                            data[i][cnt[i]*BEATW +: BEATW] <= bus.in_data[i*BEATW +: BEATW];
                            cnt[i] <= cnt[i] + 1'b1;
                            if (cnt[i] == CNT_W'(BEATS - 1))
                                st[i] <= ST_BUSY;
                        end else begin
                            // A gap in the beat stream abandons the partial word.
                            st[i]   <= ST_READY;
                            cnt[i]  <= '0;
                            data[i] <= '0;
                        end
                    end
                    ST_BUSY: begin
                        if (xfer && grant == CHW'(i)) begin
                            st[i]  <= ST_READY;
                            cnt[i] <= '0;
                        end
                    end
                    default: st[i] <= ST_READY;
                endcase
            end
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            rr_ptr    <= CHW'(NCH - 1);
            reg_state <= '0;
        end else begin
            reg_state <= state_vec;
            if (xfer)
                rr_ptr <= grant;
        end
    end

    // State-vector coverage survives reset on purpose; only meta_reset clears it.
    always_ff @(posedge clock) begin
        if (meta_reset) begin
            covmap <= '0;
            covsum <= '0;
        end else if (!covmap[reg_state]) begin
            covmap[reg_state] <= 1'b1;
            covsum            <= covsum + 1'b1;
        end
    end

    assign io_cov_sum = covsum;

    // coverage[3i+2:3i] = {is_READY, is_PENDING, in_valid[i]}
    for (genvar g = 0; g < NCH; g++) begin : g_cov
        toggle_cov u_ready (
            .clock   (clock),
            .reset   (reset),
            .signal  (st[g] == ST_READY),
            .toggled (coverage[3*g+2])
        );
        toggle_cov u_pending (
            .clock   (clock),
            .reset   (reset),
            .signal  (st[g] == ST_PENDING),
            .toggled (coverage[3*g+1])
        );
        toggle_cov u_valid (
            .clock   (clock),
            .reset   (reset),
            .signal  (bus.in_valid[g]),
            .toggled (coverage[3*g])
        );
    end

endmodule

// File: doc/mem_ctrl_multi.md
MEM_CTRL_MULTI -- requirements
Module: mem_ctrl_multi

Interface
REQ-001 SHALL have parameter NCH, default 3: number of input channels (1..4).
REQ-002 SHALL have parameter BEATW, default 2: bits per input beat.
REQ-003 SHALL have parameter BEATS, default 2: beats per transaction (1..4); DATAW = BEATW*BEATS.
REQ-004 SHALL use one clock; reset is asynchronous and active-high.
REQ-005 SHALL have port clock, input, 1: sole clock.
REQ-006 SHALL have port reset, input, 1: asynchronous active-high reset.
REQ-007 SHALL have port meta_reset, input, 1: synchronous clear of coverage state only.
REQ-008 SHALL have port in_valid, input, NCH: per-channel beat valid.
REQ-009 SHALL have port in_data, input, NCH*BEATW: channel i beat at [i*BEATW +: BEATW].
REQ-010 SHALL have port in_ready, output, NCH: channel i not BUSY.
REQ-011 SHALL have port out_valid, output, 1: a BUSY channel is presented.
REQ-012 SHALL have port out_ready, input, 1: sink accepts output.
REQ-013 SHALL have port out_data, output, DATAW: assembled word of granted channel.
REQ-014 SHALL have port out_ch, output, max(1,clog2(NCH)): granted channel index.
REQ-015 SHALL have port coverage, output, 3*NCH: toggle-coverage bits.
REQ-016 SHALL have port io_cov_sum, output, 2*NCH+1: count of distinct state vectors visited.
REQ-017 SHALL have port bug, output, 1: all channels BUSY simultaneously.

Function
REQ-018 Each channel SHALL run FSM READY -> PENDING -> BUSY with beat counter cnt.
REQ-019 READY with in_valid: data cleared, beat 0 into bits [BEATW-1:0], cnt=1; next state PENDING (BUSY if BEATS==1).
REQ-020 PENDING with in_valid: beat stored at [cnt*BEATW +: BEATW], cnt increments; enter BUSY when stored beat is BEATS-1.
REQ-021 PENDING without in_valid: abort to READY, partial data discarded, no output.
REQ-022 BUSY SHALL hold, ignoring in_valid, until the channel is granted with out_ready=1; then READY next cycle.
REQ-023 out_valid SHALL be combinational OR of BUSY flags; out_data/out_ch from grant; out_data=0 when out_valid=0.
REQ-024 Grant SHALL be round-robin: first BUSY channel after rr_ptr (wrapping); rr_ptr updates to granted index only on transfer (out_valid & out_ready).
REQ-025 Latency: last beat accepted in cycle N -> out_valid in cycle N+1.
REQ-026 bug SHALL be 1 exactly while every channel is BUSY.
REQ-027 reg_state SHALL register the concatenated state vector {ch NCH-1 .. ch0} each cycle.
REQ-028 If covmap[reg_state]==0, SHALL set it and increment covsum; io_cov_sum = covsum.
REQ-029 meta_reset SHALL clear covmap and covsum, overriding a same-cycle set/increment.
REQ-030 Toggle coverage per channel i: signals is_READY, is_PENDING, in_valid[i] at coverage[3i+2:3i]; bit sticks at 1 after first change of its signal.

Reset
REQ-031 reset SHALL asynchronously force all FSMs READY, cnt=0, data=0, rr_ptr=NCH-1, reg_state=0, toggle counters and last-values 0.
REQ-032 reset mid-transaction SHALL abort it; in_ready all-ones and out_valid=0 immediately.
REQ-033 reset SHALL NOT clear covmap or covsum; only meta_reset does.

Structure
REQ-034 State encodings (READY=0, PENDING=1, BUSY=2) SHALL live in package mem_ctrl_pkg.
REQ-035 Toggle coverage SHALL be sub-module toggle_cov (clock, reset, signal, toggled), instantiated 3*NCH times.

Verification
REQ-036 Ch0 beats 2'b01 then 2'b10, out_ready=1 -> next cycle out_valid=1, out_data=4'b1001, out_ch=0; ch0 READY after.
REQ-037 Ch1 in_valid one cycle then low -> ch1 READY, out_valid never asserts.
REQ-038 All three channels complete together, out_ready=0 -> bug=1 held; out_ready=1 -> out_ch 0,1,2 on consecutive cycles, bug=0.
REQ-039 Ch0 and ch2 re-BUSY continuously, out_ready=1 -> grants alternate 0,2,0,2.
REQ-040 Idle after reset -> io_cov_sum=1 by cycle 2; meta_reset -> 0; reset alone leaves value unchanged.
REQ-041 Async reset asserted mid-PENDING between clock edges -> in_ready=3'b111 before next edge.
